// File: rtl/hit_serializer_pkg.sv
// hit_serializer_pkg: shared geometry constants, the hit-group record stored in the
// serializer FIFO, and the lowest-lane priority helper.
//   SIGFIG/RADIX/AXIS/COLORS/MULTI_TEST : datapath geometry (RADIX is carried only)
//   HIT_FIFO_DEPTH                       : default FIFO depth in hit groups
package hit_serializer_pkg;

  localparam int unsigned SIGFIG         = 24;
  localparam int unsigned RADIX          = 10;
  localparam int unsigned AXIS           = 3;
  localparam int unsigned COLORS         = 3;
  localparam int unsigned MULTI_TEST     = 4;
  localparam int unsigned HIT_FIFO_DEPTH = 8;
  localparam int unsigned LANE_W         = (MULTI_TEST > 1) ? $clog2(MULTI_TEST) : 1;

  typedef logic [AXIS-1:0][SIGFIG-1:0]   pos_t;
  typedef logic [COLORS-1:0][SIGFIG-1:0] color_t;
  typedef logic [MULTI_TEST-1:0]         mask_t;

  typedef struct packed {
    pos_t [MULTI_TEST-1:0] pos;
    color_t                color;
    mask_t                 mask;
  } hit_group_t;

  // Index of the lowest set bit; 0 for an empty mask.
  function automatic logic [LANE_W-1:0] lowest_lane(input mask_t m);
    logic [LANE_W-1:0] l;
    l = '0;
    for (int i = MULTI_TEST - 1; i >= 0; i--) begin
      if (m[i]) l = LANE_W'(i);
    end
    return l;
  endfunction

endpackage

// File: rtl/hit_serializer_if.sv
// hit_serializer_if: bundles the rast-side group inputs, the halt feedback, the serialized
// hit stream with its valid/ready handshake, and the stats counters.
//   master : environment side (drives groups and hit_ready)
//   slave  : serializer side (drives halt, hit stream and stats)
interface hit_serializer_if;
  import hit_serializer_pkg::*;

  logic signed [MULTI_TEST-1:0][AXIS-1:0][SIGFIG-1:0] hit_R18S;
  color_t                                             color_R18U;
  mask_t                                              hit_valid_R18H;
  logic                                               halt_RnnnnL;
  logic signed [AXIS-1:0][SIGFIG-1:0]                 hit_S;
  color_t                                             hit_color_U;
  logic [LANE_W-1:0]                                  hit_lane_U;
  logic                                               hit_valid;
  logic                                               hit_ready;
  logic [31:0]                                        hit_count;
  logic [31:0]                                        drop_count;

  modport master (
    output hit_R18S, color_R18U, hit_valid_R18H, hit_ready,
    input  halt_RnnnnL, hit_S, hit_color_U, hit_lane_U, hit_valid, hit_count, drop_count
  );

  modport slave (
    input  hit_R18S, color_R18U, hit_valid_R18H, hit_ready,
    output halt_RnnnnL, hit_S, hit_color_U, hit_lane_U, hit_valid, hit_count, drop_count
  );

endinterface

// File: rtl/hit_group_fifo.sv
// hit_group_fifo: circular buffer of hit groups with occupancy count.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en_i    : push wr_data_i (caller guarantees room, allowing a same-edge pop)
//   rd_en_i    : pop the head entry
//   rd_data_o  : head entry (meaningless while empty_o)
//   count_o    : occupancy; full_o / empty_o decoded from it
module hit_group_fifo
  import hit_serializer_pkg::*;
#(
  parameter int unsigned Depth = HIT_FIFO_DEPTH,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  hit_group_t      wr_data_i,
  input  logic            rd_en_i,
  output hit_group_t      rd_data_o,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  hit_group_t      mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(wr_en_i) - CntW'(rd_en_i);
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CntW'(Depth));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/hit_serializer.sv
// hit_serializer: buffers parallel sample-test hit groups from rast and emits them one hit
// per cycle, lowest lane first, with an active-low halt back to rast.
//   clk, rst : clock, synchronous active-high reset
//   bus      : hit_serializer_if.slave (group inputs, halt, hit stream, stats)
// Optional feature: define HIT_SERIALIZER_STATS_EN to build the hit/drop counters;
// otherwise hit_count and drop_count read 0.
module hit_serializer
  import hit_serializer_pkg::*;
#(
  parameter int unsigned DEPTH = HIT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  hit_serializer_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  if (RADIX >= SIGFIG) begin : g_radix_chk
    $error("RADIX must be smaller than SIGFIG");
  end
  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("DEPTH must be a power of two and at least 4");
  end

  hit_group_t        wr_group, head;
  logic [CntW-1:0]   count, count_next;
  logic              full, empty;
  logic              any_in, push, emit, pop;
  mask_t             pending, lane_bit, done_q, done_d;
  logic [LANE_W-1:0] lane;
  logic              halt_q, halt_d;
  pos_t              last_pos_q;
  color_t            last_color_q;
  logic [LANE_W-1:0] last_lane_q;

  always_comb begin
    wr_group.pos   = bus.hit_R18S;
    wr_group.color = bus.color_R18U;
    wr_group.mask  = bus.hit_valid_R18H;
  end

  hit_group_fifo #(
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push),
    .wr_data_i (wr_group),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  // done_q marks lanes of the head group already emitted; the pending mask is the head mask
  // minus those, which is equivalent to reloading a pending register on every pop.
  always_comb begin
    pending    = head.mask & ~done_q;
    lane       = lowest_lane(pending);
    lane_bit   = mask_t'(1) << lane;
    emit       = !empty && bus.hit_ready;
    pop        = emit && ((pending & ~lane_bit) == '0);
    any_in     = |bus.hit_valid_R18H;
    push       = any_in && (!full || pop);
    count_next = count + CntW'(push) - CntW'(pop);
    // Two spare slots absorb rast's one-cycle halt response plus the group in flight.
    halt_d     = !(count_next >= CntW'(DEPTH - 2));
    done_d     = done_q;
    if (pop)       done_d = '0;
    else if (emit) done_d = done_q | lane_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q       <= '0;
      halt_q       <= 1'b1;
      last_pos_q   <= '0;
      last_color_q <= '0;
      last_lane_q  <= '0;
    end else begin
      done_q <= done_d;
      halt_q <= halt_d;
      if (emit) begin
        last_pos_q   <= head.pos[lane];
        last_color_q <= head.color;
        last_lane_q  <= lane;
      end
    end
  end

  // While empty the stream holds the most recently emitted hit.
  assign bus.hit_valid   = !empty;
  assign bus.hit_S       = empty ? last_pos_q   : head.pos[lane];
  assign bus.hit_color_U = empty ? last_color_q : head.color;
  assign bus.hit_lane_U  = empty ? last_lane_q  : lane;
  assign bus.halt_RnnnnL = halt_q;

`ifdef HIT_SERIALIZER_STATS_EN
  logic        drop;
  logic [31:0] hit_count_q, drop_count_q;

  assign drop = any_in && !push;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (emit) hit_count_q  <= hit_count_q + 32'd1;
      if (drop) drop_count_q <= drop_count_q + 32'd1;
    end
  end

  assign bus.hit_count  = hit_count_q;
  assign bus.drop_count = drop_count_q;
`else
  assign bus.hit_count  = '0;
  assign bus.drop_count = '0;
`endif

endmodule

// File: tb/tb_hit_serializer.sv
// tb_hit_serializer: randomized and directed stimulus for hit_serializer, checked against a
// queue-of-groups reference model (each entry keeps its remaining lane mask).
module tb_hit_serializer;
  import hit_serializer_pkg::*;

  localparam int unsigned DEPTH = HIT_FIFO_DEPTH;
`ifdef HIT_SERIALIZER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [MULTI_TEST-1:0][AXIS-1:0][SIGFIG-1:0] pos;
    color_t                                      color;
    mask_t                                       mask;
  } grp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hit_serializer_if bus ();

  hit_serializer #(
    .DEPTH (DEPTH)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  grp_t        mq[$];
  grp_t        last_in;
  int unsigned m_hits, m_drops;
  bit          m_halt;
  pos_t        m_last_pos;
  color_t      m_last_color;
  int          m_last_lane;
  int          checks = 0;
  int          errors = 0;

  function automatic int first_lane(input mask_t m);
    for (int i = 0; i < MULTI_TEST; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int unsigned v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, return at the negedge.
  task automatic cycle(input bit r, input mask_t m, input bit rdy);
    grp_t g, h;
    bit   popped;
    int   sz, ln;
    for (int i = 0; i < MULTI_TEST; i++)
      for (int a = 0; a < AXIS; a++) g.pos[i][a] = SIGFIG'($urandom);
    for (int c = 0; c < COLORS; c++) g.color[c] = SIGFIG'($urandom);
    g.mask = m;
    last_in = g;
    rst = r;
    bus.hit_R18S = g.pos;
    bus.color_R18U = g.color;
    bus.hit_valid_R18H = m;
    bus.hit_ready = rdy;
    if (r) begin
      mq.delete();
      m_hits = 0; m_drops = 0; m_halt = 1'b1;
      m_last_pos = '0; m_last_color = '0; m_last_lane = 0;
    end else begin
      popped = 1'b0;
      sz = mq.size();
      if (sz > 0 && rdy) begin
        h = mq[0];
        ln = first_lane(h.mask);
        m_last_pos = h.pos[ln];
        m_last_color = h.color;
        m_last_lane = ln;
        h.mask[ln] = 1'b0;
        m_hits++;
        if (h.mask == '0) begin
          void'(mq.pop_front());
          popped = 1'b1;
        end else begin
          mq[0] = h;
        end
      end
      if (m != '0) begin
        if (sz < int'(DEPTH) || popped) mq.push_back(g);
        else m_drops++;
      end
      m_halt = !(mq.size() >= int'(DEPTH) - 2);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b1, '0, 1'b0);
    cycle(1'b1, '0, 1'b0);
    checks++;
    if (bus.hit_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b, expected 0", bus.hit_valid);
    end
    checks++;
    if (bus.halt_RnnnnL !== 1'b1) begin
      errors++; $display("FAIL reset_halt: got %0b, expected 1", bus.halt_RnnnnL);
    end
    checks++;
    if ({bus.hit_S, bus.hit_color_U, bus.hit_lane_U} !== '0) begin
      errors++; $display("FAIL reset_outputs: got pos=%h col=%h lane=%0d, expected all 0",
                         bus.hit_S, bus.hit_color_U, bus.hit_lane_U);
    end
    checks++;
    if (bus.hit_count !== 32'd0 || bus.drop_count !== 32'd0) begin
      errors++; $display("FAIL reset_counters: got hits=%0d drops=%0d, expected 0 0",
                         bus.hit_count, bus.drop_count);
    end
  endtask

  task automatic test_single();
    grp_t g;
    cycle(1'b0, 4'b1010, 1'b1);
    g = last_in;
    checks++;
    if (bus.hit_valid !== 1'b1 || bus.hit_lane_U !== LANE_W'(1) || bus.hit_S !== g.pos[1] ||
        bus.hit_color_U !== g.color) begin
      errors++; $display("FAIL single_first: got v=%0b lane=%0d pos=%h col=%h, expected 1 1 %h %h",
                         bus.hit_valid, bus.hit_lane_U, bus.hit_S, bus.hit_color_U,
                         g.pos[1], g.color);
    end
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.hit_valid !== 1'b1 || bus.hit_lane_U !== LANE_W'(3) || bus.hit_S !== g.pos[3] ||
        bus.hit_color_U !== g.color) begin
      errors++; $display("FAIL single_second: got v=%0b lane=%0d pos=%h col=%h, expected 1 3 %h %h",
                         bus.hit_valid, bus.hit_lane_U, bus.hit_S, bus.hit_color_U,
                         g.pos[3], g.color);
    end
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.hit_valid !== 1'b0 || bus.hit_lane_U !== LANE_W'(3) || bus.hit_S !== g.pos[3]) begin
      errors++; $display("FAIL single_done: got v=%0b lane=%0d pos=%h, expected 0 3 %h (held)",
                         bus.hit_valid, bus.hit_lane_U, bus.hit_S, g.pos[3]);
    end
    checks++;
    if (bus.hit_count !== (STATS ? 32'd2 : 32'd0)) begin
      errors++; $display("FAIL single_hit_count: got %0d, expected %0d", bus.hit_count,
                         STATS ? 2 : 0);
    end
  endtask

  task automatic test_overflow();
    int occ, budget;
    cycle(1'b1, '0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b0, 4'hF, 1'b0);
      occ = (i > 8) ? 8 : i;
      checks++;
      if (bus.halt_RnnnnL !== (occ < 6) || bus.hit_valid !== 1'b1) begin
        errors++; $display("FAIL overflow_halt group %0d: got halt=%0b v=%0b, expected %0b 1", i,
                           bus.halt_RnnnnL, bus.hit_valid, occ < 6);
      end
      checks++;
      if (bus.drop_count !== exp_cnt((i > 8) ? i - 8 : 0)) begin
        errors++; $display("FAIL overflow_drops group %0d: got %0d, expected %0d", i,
                           bus.drop_count, exp_cnt((i > 8) ? i - 8 : 0));
      end
    end
    budget = 64;
    while (bus.hit_valid === 1'b1 && budget > 0) begin
      cycle(1'b0, '0, 1'b1);
      budget--;
    end
    checks++;
    if (budget == 0 || bus.hit_count !== exp_cnt(32)) begin
      errors++; $display("FAIL overflow_drain: got hits=%0d budget_left=%0d, expected %0d emptied",
                         bus.hit_count, budget, exp_cnt(32));
    end
  endtask

  task automatic test_ready_toggle();
    grp_t              g;
    pos_t              ps;
    color_t            pc;
    logic [LANE_W-1:0] pl;
    bit                rd;
    int                k;
    cycle(1'b1, '0, 1'b0);
    cycle(1'b0, 4'b0111, 1'b0);
    g = last_in;
    k = 0;
    for (int s = 0; s < 5; s++) begin
      rd = (s % 2 == 0);
      ps = bus.hit_S; pc = bus.hit_color_U; pl = bus.hit_lane_U;
      if (rd) begin
        checks++;
        if (pl !== LANE_W'(k) || ps !== g.pos[k] || pc !== g.color) begin
          errors++; $display("FAIL toggle_lane step %0d: got lane=%0d pos=%h, expected %0d %h",
                             s, pl, ps, k, g.pos[k]);
        end
        k++;
      end
      cycle(1'b0, '0, rd);
      if (!rd) begin
        checks++;
        if (bus.hit_S !== ps || bus.hit_color_U !== pc || bus.hit_lane_U !== pl) begin
          errors++; $display("FAIL toggle_stable step %0d: got lane=%0d pos=%h, expected %0d %h",
                             s, bus.hit_lane_U, bus.hit_S, pl, ps);
        end
      end
    end
    checks++;
    if (bus.hit_valid !== 1'b0) begin
      errors++; $display("FAIL toggle_end_valid: got %0b, expected 0", bus.hit_valid);
    end
  endtask

  task automatic test_zero_mask();
    cycle(1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0, 1'($urandom_range(0, 1)));
      checks++;
      if (bus.hit_valid !== 1'b0 || bus.halt_RnnnnL !== 1'b1) begin
        errors++; $display("FAIL zero_mask cycle %0d: got v=%0b halt=%0b, expected 0 1", i,
                           bus.hit_valid, bus.halt_RnnnnL);
      end
    end
    checks++;
    if (bus.hit_count !== 32'd0 || bus.drop_count !== 32'd0) begin
      errors++; $display("FAIL zero_mask_counters: got %0d %0d, expected 0 0",
                         bus.hit_count, bus.drop_count);
    end
  endtask

  task automatic test_full_pop_write();
    mask_t second;
    cycle(1'b1, '0, 1'b0);
    cycle(1'b0, 4'b0100, 1'b0);
    second = mask_t'($urandom_range(1, 15));
    cycle(1'b0, second, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, mask_t'($urandom_range(1, 15)), 1'b0);
    checks++;
    if (bus.drop_count !== 32'd0 || bus.halt_RnnnnL !== 1'b0) begin
      errors++; $display("FAIL full_fill: got drops=%0d halt=%0b, expected 0 0",
                         bus.drop_count, bus.halt_RnnnnL);
    end
    cycle(1'b0, 4'b0001, 1'b1);
    checks++;
    if (bus.drop_count !== 32'd0 || bus.hit_valid !== 1'b1 ||
        bus.hit_lane_U !== LANE_W'(first_lane(second))) begin
      errors++; $display("FAIL full_pop_write: got drops=%0d v=%0b lane=%0d, expected 0 1 %0d",
                         bus.drop_count, bus.hit_valid, bus.hit_lane_U, first_lane(second));
    end
    cycle(1'b0, 4'b0010, 1'b0);
    checks++;
    if (bus.drop_count !== exp_cnt(1)) begin
      errors++; $display("FAIL full_still_full: got drops=%0d, expected %0d",
                         bus.drop_count, exp_cnt(1));
    end
  endtask

  task automatic test_reset_mid();
    grp_t g;
    cycle(1'b1, '0, 1'b0);
    cycle(1'b0, 4'b0111, 1'b1);
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.hit_count !== exp_cnt(1) || bus.hit_lane_U !== LANE_W'(1)) begin
      errors++; $display("FAIL midreset_pre: got hits=%0d lane=%0d, expected %0d 1",
                         bus.hit_count, bus.hit_lane_U, exp_cnt(1));
    end
    cycle(1'b1, '0, 1'b1);
    checks++;
    if (bus.hit_valid !== 1'b0 || bus.halt_RnnnnL !== 1'b1 || bus.hit_count !== 32'd0 ||
        bus.drop_count !== 32'd0 || {bus.hit_S, bus.hit_lane_U} !== '0) begin
      errors++; $display("FAIL midreset_post: got v=%0b halt=%0b hits=%0d lane=%0d, expected 0 1 0 0",
                         bus.hit_valid, bus.halt_RnnnnL, bus.hit_count, bus.hit_lane_U);
    end
    cycle(1'b0, 4'b1001, 1'b1);
    g = last_in;
    checks++;
    if (bus.hit_lane_U !== LANE_W'(0) || bus.hit_S !== g.pos[0]) begin
      errors++; $display("FAIL midreset_fresh0: got lane=%0d pos=%h, expected 0 %h",
                         bus.hit_lane_U, bus.hit_S, g.pos[0]);
    end
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.hit_lane_U !== LANE_W'(3) || bus.hit_S !== g.pos[3]) begin
      errors++; $display("FAIL midreset_fresh3: got lane=%0d pos=%h, expected 3 %h",
                         bus.hit_lane_U, bus.hit_S, g.pos[3]);
    end
    cycle(1'b0, '0, 1'b1);
    checks++;
    if (bus.hit_valid !== 1'b0 || bus.hit_count !== exp_cnt(2)) begin
      errors++; $display("FAIL midreset_end: got v=%0b hits=%0d, expected 0 %0d",
                         bus.hit_valid, bus.hit_count, exp_cnt(2));
    end
  endtask

  task automatic test_random();
    mask_t  m;
    bit     rdy, ev;
    int     el, ready_pct;
    pos_t   ep;
    color_t ec;
    cycle(1'b1, '0, 1'b0);
    for (int n = 0; n < 400; n++) begin
      ready_pct = ((n / 100) % 2 == 0) ? 85 : 30;
      m = ($urandom_range(0, 3) == 0) ? '0 : mask_t'($urandom_range(1, 15));
      if (bus.halt_RnnnnL === 1'b0 && $urandom_range(0, 1) == 1) m = '0;
      rdy = ($urandom_range(1, 100) <= ready_pct);
      cycle(1'b0, m, rdy);
      ev = (mq.size() != 0);
      if (ev) begin
        el = first_lane(mq[0].mask); ep = mq[0].pos[el]; ec = mq[0].color;
      end else begin
        el = m_last_lane; ep = m_last_pos; ec = m_last_color;
      end
      checks++;
      if (bus.hit_valid !== ev || bus.halt_RnnnnL !== m_halt || bus.hit_lane_U !== LANE_W'(el) ||
          bus.hit_S !== ep || bus.hit_color_U !== ec || bus.hit_count !== exp_cnt(m_hits) ||
          bus.drop_count !== exp_cnt(m_drops)) begin
        errors++;
        $display("FAIL random cycle %0d: got v=%0b h=%0b lane=%0d pos=%h col=%h hits=%0d drops=%0d, expected v=%0b h=%0b lane=%0d pos=%h col=%h hits=%0d drops=%0d",
                 n, bus.hit_valid, bus.halt_RnnnnL, bus.hit_lane_U, bus.hit_S, bus.hit_color_U,
                 bus.hit_count, bus.drop_count, ev, m_halt, el, ep, ec, exp_cnt(m_hits),
                 exp_cnt(m_drops));
      end
    end
  endtask

  initial begin
    bus.hit_R18S = '0;
    bus.color_R18U = '0;
    bus.hit_valid_R18H = '0;
    bus.hit_ready = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_ready_toggle();
    test_zero_mask();
    test_full_pop_write();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
